hazard_forward_unit: RTL and testbench
======================================

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 SHALL have parameter FWD_DEPTH, default 3, number of tracked writeback stages (>=1).
REQ-002 SHALL have parameter REG_COUNT, default 32, architectural register count (>=2); AW = $clog2(REG_COUNT).
REQ-003 SHALL have parameter NUM_READ, default 2, read operand ports (>=1).
REQ-004 SHALL have parameter ZERO_REG_HARDWIRED, default 1, register 0 never forwarded when 1.
REQ-005 SHALL have parameter LOAD_READY_STAGE, default 1, first stage index holding load data (0..FWD_DEPTH).
REQ-006 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports: clk_en in 1 global advance; flush in 1 discard all tracked writes.
REQ-008 SHALL have ports: issue_valid in 1; issue_wr_en in 1; issue_wr_addr in AW; issue_is_load in 1 (instruction entering stage 0).
REQ-009 SHALL have ports: rd_en in NUM_READ; rd_addr in NUM_READ*AW (operand j at bits [j*AW +: AW]).
REQ-010 SHALL have ports: fwd_onehot out NUM_READ*FWD_DEPTH (operand j at [j*FWD_DEPTH +: FWD_DEPTH], bit i = forward from stage i).
REQ-011 SHALL have ports: stall out 1 load-use stall; stage_valid out FWD_DEPTH; stall_cnt out 16 stall-cycle counter.

Function
REQ-012 SHALL hold per stage i a registered entry {valid, wr_addr, is_load}; stage_valid[i] = entry valid.
REQ-013 Stage-0 candidate SHALL be valid = issue_valid & issue_wr_en & !(ZERO_REG_HARDWIRED & issue_wr_addr==0).
REQ-014 On clk edge with clk_en=1, flush=0, stall=0: stage0 <= candidate; stage i <= stage i-1.
REQ-015 On clk edge with clk_en=1, flush=0, stall=1: stage0 <= bubble (valid=0); stage i <= stage i-1 (older work drains).
REQ-016 On clk edge with clk_en=1, flush=1: all valid <= 0 regardless of stall or issue; addr/is_load don't-care.
REQ-017 With clk_en=0 no state SHALL change (flush ignored).
REQ-018 Match(i,j) SHALL be valid[i] & rd_en[j] & rd_addr[j]==wr_addr[i] & !(ZERO_REG_HARDWIRED & rd_addr[j]==0).
REQ-019 Per operand, lowest matching i (youngest) SHALL win; fwd_onehot at most one bit set per operand.
REQ-020 If winning stage i has is_load=1 and i < LOAD_READY_STAGE: that operand's fwd_onehot = 0 and operand is load-blocked.
REQ-021 stall = issue_valid & (any operand load-blocked); combinational, zero latency from inputs and state.
REQ-022 fwd_onehot and stall SHALL be combinational from current registered entries and current rd_*/issue_valid; a write issued at cycle N is matchable at stage 0 from cycle N+1.
REQ-023 An older match behind a younger load-blocked match SHALL NOT be forwarded.
REQ-024 LOAD_READY_STAGE=0 SHALL never stall; LOAD_READY_STAGE=FWD_DEPTH blocks loads in every tracked stage.
REQ-025 stall_cnt SHALL increment on each clk edge with clk_en=1 and stall=1, saturate at 0xFFFF, clear only on reset.
REQ-026 Entry leaving stage FWD_DEPTH-1 SHALL be dropped; reads matching no stage give fwd_onehot=0 (register file).

Reset
REQ-027 rst=1 SHALL asynchronously clear all entry valid, wr_addr, is_load to 0 and stall_cnt to 0.
REQ-028 During and after reset until first issue: stage_valid=0, fwd_onehot=0, stall=0.
REQ-029 Reset asserted mid-stall SHALL drop stall immediately and discard all tracked writes.

Verification (defaults: D=3, REG=32, NR=2, LRS=1)
REQ-030 Issue wr x5 (non-load) cycle 0; rd_addr[0]=5 cycles 1,2,3 -> fwd_onehot op0 = 001,010,100; cycle 4 -> 000.
REQ-031 Issue wr x7 cycle 0, wr x7 cycle 1; read x7 cycle 2 -> op0 onehot 001 (youngest), not 010.
REQ-032 Load to x3 cycle 0; issue_valid, rd x3 cycle 1 -> stall=1, onehot 000; next cycle stage0 bubble, stage1 load -> onehot 010, stall=0; stall_cnt=1.
REQ-033 Write x0 issued, read x0 next cycle -> stage_valid[0]=0, onehot 000, stall 0.
REQ-034 Three writes tracked, flush with clk_en=1 -> stage_valid=000 next cycle; with clk_en=0 flush -> unchanged.
REQ-035 Force 65537 stall cycles -> stall_cnt=0xFFFF; assert rst mid-stall -> stall=0, stall_cnt=0 immediately.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// Tracks in-flight register writes across FWD_DEPTH writeback stages and selects a forwarding source per read operand.
// Raises a load-use stall when the youngest producer is a load whose data is not yet available.
module hazard_forward_unit #(
    parameter int FWD_DEPTH          = 3,
    parameter int REG_COUNT          = 32,
    parameter int NUM_READ           = 2,
    parameter int ZERO_REG_HARDWIRED = 1,
    parameter int LOAD_READY_STAGE   = 1,
    localparam int AW = $clog2(REG_COUNT)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clk_en,
    input  logic                          flush,
    input  logic                          issue_valid,
    input  logic                          issue_wr_en,
    input  logic [AW-1:0]                 issue_wr_addr,
    input  logic                          issue_is_load,
    input  logic [NUM_READ-1:0]           rd_en,
    input  logic [NUM_READ*AW-1:0]        rd_addr,
    output logic [NUM_READ*FWD_DEPTH-1:0] fwd_onehot,
    output logic                          stall,
    output logic [FWD_DEPTH-1:0]          stage_valid,
    output logic [15:0]                   stall_cnt
);

    logic [FWD_DEPTH-1:0] valid_q;
    logic [FWD_DEPTH-1:0] load_q;
    logic [AW-1:0]        addr_q [FWD_DEPTH];
    logic [NUM_READ-1:0]  blocked;
    logic                 cand_valid;

    assign cand_valid  = issue_valid & issue_wr_en &
                         ~((ZERO_REG_HARDWIRED != 0) && (issue_wr_addr == '0));
    assign stage_valid = valid_q;
    assign stall       = issue_valid & (|blocked);

    // Youngest matching stage wins; if it is an unready load, nothing older may be used.
    always_comb begin
        logic          hit;
        logic [AW-1:0] ra;
        hit        = 1'b0;
        ra         = '0;
        fwd_onehot = '0;
        blocked    = '0;
        for (int j = 0; j < NUM_READ; j++) begin
            hit = 1'b0;
            ra  = rd_addr[j*AW +: AW];
            for (int i = 0; i < FWD_DEPTH; i++) begin
                if (!hit && valid_q[i] && rd_en[j] && (ra == addr_q[i]) &&
                    !((ZERO_REG_HARDWIRED != 0) && (ra == '0))) begin
                    hit = 1'b1;
                    if (load_q[i] && (i < LOAD_READY_STAGE))
                        blocked[j] = 1'b1;
                    else
                        fwd_onehot[j*FWD_DEPTH + i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            load_q  <= '0;
            for (int i = 0; i < FWD_DEPTH; i++)
                addr_q[i] <= '0;
        end else if (clk_en) begin
            if (flush) begin
                valid_q <= '0;
            end else begin
                valid_q[0] <= cand_valid & ~stall;
                addr_q[0]  <= issue_wr_addr;
                load_q[0]  <= issue_is_load;
                for (int i = 1; i < FWD_DEPTH; i++) begin
                    valid_q[i] <= valid_q[i-1];
                    addr_q[i]  <= addr_q[i-1];
                    load_q[i]  <= load_q[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (clk_en && stall && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench: stimulus pushes model predictions, a monitor compares the DUT mid-cycle.
// A second deep instance with every stage load-blocked drives the stall counter to saturation.
module tb_hazard_forward_unit;
    localparam int D   = 3;
    localparam int NR  = 2;
    localparam int AW  = 5;
    localparam int LRS = 1;
    localparam int D2  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, clk_en, flush, issue_valid, issue_wr_en, issue_is_load;
    logic [AW-1:0]     issue_wr_addr;
    logic [NR-1:0]     rd_en;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*D-1:0]   fwd_onehot;
    logic              stall;
    logic [D-1:0]      stage_valid;
    logic [15:0]       stall_cnt;

    logic              d2_rst, d2_clk_en, d2_flush, d2_iv, d2_we, d2_ld;
    logic [AW-1:0]     d2_wa;
    logic [NR-1:0]     d2_re;
    logic [NR*AW-1:0]  d2_ra;
    logic [NR*D2-1:0]  d2_fwd;
    logic              d2_stall;
    logic [D2-1:0]     d2_sv;
    logic [15:0]       d2_cnt;

    hazard_forward_unit dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush),
        .issue_valid(issue_valid), .issue_wr_en(issue_wr_en),
        .issue_wr_addr(issue_wr_addr), .issue_is_load(issue_is_load),
        .rd_en(rd_en), .rd_addr(rd_addr), .fwd_onehot(fwd_onehot),
        .stall(stall), .stage_valid(stage_valid), .stall_cnt(stall_cnt)
    );

    hazard_forward_unit #(.FWD_DEPTH(D2), .LOAD_READY_STAGE(D2)) dut_deep (
        .clk(clk), .rst(d2_rst), .clk_en(d2_clk_en), .flush(d2_flush),
        .issue_valid(d2_iv), .issue_wr_en(d2_we),
        .issue_wr_addr(d2_wa), .issue_is_load(d2_ld),
        .rd_en(d2_re), .rd_addr(d2_ra), .fwd_onehot(d2_fwd),
        .stall(d2_stall), .stage_valid(d2_sv), .stall_cnt(d2_cnt)
    );

    typedef struct {
        bit          v;
        bit [AW-1:0] a;
        bit          ld;
    } ent_t;

    typedef struct {
        logic [NR*D-1:0] fwd;
        logic            stall;
        logic [D-1:0]    sv;
        logic [15:0]     cnt;
        int              id;
    } exp_t;

    ent_t pipe[$];     // index 0 = youngest tracked write
    exp_t exp_q[$];
    int   cnt_m;
    int   vectors = 0;
    int   miscompares = 0;
    int   issued = 0;

    function automatic void model_reset();
        ent_t z;
        z.v = 1'b0; z.a = '0; z.ld = 1'b0;
        pipe.delete();
        for (int i = 0; i < D; i++) pipe.push_back(z);
        cnt_m = 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, want);
        end
    endtask

    task automatic drive(input bit r, input bit ce, input bit fl, input bit iv, input bit we,
                         input bit ld, input bit [AW-1:0] wa, input bit [NR-1:0] re,
                         input bit [AW-1:0] ra0, input bit [AW-1:0] ra1);
        exp_t        e;
        ent_t        c;
        bit [AW-1:0] ra;
        int          idx;
        @(negedge clk);
        rst = r; clk_en = ce; flush = fl; issue_valid = iv; issue_wr_en = we;
        issue_is_load = ld; issue_wr_addr = wa; rd_en = re; rd_addr = {ra1, ra0};
        if (r) model_reset();
        e.fwd = '0;
        e.stall = 1'b0;
        for (int j = 0; j < NR; j++) begin
            ra = (j == 0) ? ra0 : ra1;
            if (!re[j] || ra == 0) continue;
            idx = -1;
            for (int i = 0; i < pipe.size(); i++)
                if (pipe[i].v && pipe[i].a == ra) begin
                    idx = i;
                    break;
                end
            if (idx < 0) continue;
            if (pipe[idx].ld && idx < LRS) e.stall = e.stall | iv;
            else e.fwd[j*D + idx] = 1'b1;
        end
        for (int i = 0; i < D; i++) e.sv[i] = pipe[i].v;
        e.cnt = cnt_m[15:0];
        e.id  = issued++;
        exp_q.push_back(e);
        if (!r && ce) begin
            if (e.stall && cnt_m < 65535) cnt_m++;
            if (fl) begin
                for (int i = 0; i < pipe.size(); i++) pipe[i].v = 1'b0;
            end else begin
                c.v  = iv && we && (wa != 0) && !e.stall;
                c.a  = wa;
                c.ld = ld;
                pipe.push_front(c);
                void'(pipe.pop_back());
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (fwd_onehot !== e.fwd || stall !== e.stall || stage_valid !== e.sv ||
                    stall_cnt !== e.cnt) begin
                    miscompares++;
                    $display("FAIL vec%0d: fwd=%b stall=%b sv=%b cnt=%h, required fwd=%b stall=%b sv=%b cnt=%h",
                             e.id, fwd_onehot, stall, stage_valid, stall_cnt,
                             e.fwd, e.stall, e.sv, e.cnt);
                end
            end
        end
    end

    logic [2:0] w030 [4] = '{3'b001, 3'b010, 3'b100, 3'b000};
    int stalls_m, stall_err;

    initial begin : stimulus
        rst = 1'b1; clk_en = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_wr_en = 1'b0;
        issue_is_load = 1'b0; issue_wr_addr = '0; rd_en = '0; rd_addr = '0;
        d2_rst = 1'b1; d2_clk_en = 1'b1; d2_flush = 1'b0; d2_iv = 1'b0; d2_we = 1'b0;
        d2_ld = 1'b0; d2_wa = '0; d2_re = '0; d2_ra = '0;
        model_reset();

        // reset held with active-looking inputs
        drive(1, 1, 0, 1, 1, 0, 5'd4, 2'b11, 5'd4, 5'd0);
        drive(1, 1, 1, 1, 1, 1, 5'd9, 2'b11, 5'd9, 5'd9);
        drive(0, 1, 0, 0, 0, 0, 5'd0, 2'b00, 5'd0, 5'd0);

        // forwarding walks through stages then falls to the register file
        drive(0, 1, 0, 1, 1, 0, 5'd5, 2'b00, 5'd0, 5'd0);
        for (int c = 0; c < 4; c++) begin
            drive(0, 1, 0, 0, 0, 0, 5'd0, 2'b01, 5'd5, 5'd0);
            #3 chk($sformatf("walk_c%0d", c + 1), 32'(fwd_onehot[2:0]), 32'(w030[c]));
        end

        // youngest producer wins
        drive(0, 1, 0, 1, 1, 0, 5'd7, 2'b00, 5'd0, 5'd0);
        drive(0, 1, 0, 1, 1, 0, 5'd7, 2'b00, 5'd0, 5'd0);
        drive(0, 1, 0, 0, 0, 0, 5'd0, 2'b01, 5'd7, 5'd0);
        #3 chk("youngest", 32'(fwd_onehot[2:0]), 32'h1);

        // load-use stall then forward from stage 1
        drive(0, 1, 0, 1, 1, 1, 5'd3, 2'b00, 5'd0, 5'd0);
        drive(0, 1, 0, 1, 0, 0, 5'd0, 2'b01, 5'd3, 5'd0);
        #3 chk("load_stall", 32'(stall), 32'h1);
        chk("load_fwd_blocked", 32'(fwd_onehot[2:0]), 32'h0);
        drive(0, 1, 0, 1, 0, 0, 5'd0, 2'b01, 5'd3, 5'd0);
        #3 chk("load_fwd_s1", 32'(fwd_onehot[2:0]), 32'h2);
        chk("load_unstall", 32'(stall), 32'h0);
        chk("load_stall_cnt", 32'(stall_cnt), 32'h1);

        // x0 is never tracked
        drive(0, 1, 0, 1, 1, 0, 5'd0, 2'b00, 5'd0, 5'd0);
        drive(0, 1, 0, 1, 0, 0, 5'd0, 2'b11, 5'd0, 5'd0);
        #3 chk("x0_stage0", 32'(stage_valid[0]), 32'h0);
        chk("x0_fwd", 32'(fwd_onehot), 32'h0);

        // flush ignored without clk_en, honoured with it
        drive(0, 1, 0, 1, 1, 0, 5'd1, 2'b00, 5'd0, 5'd0);
        drive(0, 1, 0, 1, 1, 0, 5'd2, 2'b00, 5'd0, 5'd0);
        drive(0, 1, 0, 1, 1, 0, 5'd4, 2'b00, 5'd0, 5'd0);
        drive(0, 0, 1, 1, 1, 0, 5'd6, 2'b00, 5'd0, 5'd0);
        drive(0, 1, 1, 1, 1, 0, 5'd6, 2'b00, 5'd0, 5'd0);
        #3 chk("flush_gated", 32'(stage_valid), 32'h7);
        drive(0, 1, 0, 0, 0, 0, 5'd0, 2'b00, 5'd0, 5'd0);
        #3 chk("flush_done", 32'(stage_valid), 32'h0);

        for (int k = 0; k < 3000; k++)
            drive(0, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 4,
                  $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 75,
                  $urandom_range(0, 99) < 30, 5'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)));
        drive(0, 0, 0, 0, 0, 0, 5'd0, 2'b00, 5'd0, 5'd0);
        @(negedge clk);
        #3 chk("scoreboard_drain", 32'(exp_q.size()), 32'h0);

        // deep instance: every stage blocks a load, so 16 stalls per issued load
        @(negedge clk);
        d2_rst = 1'b0;
        stalls_m = 0;
        stall_err = 0;
        while (stalls_m < 65537) begin
            @(negedge clk);
            d2_iv = 1'b1; d2_we = 1'b1; d2_ld = 1'b1; d2_wa = 5'd3; d2_re = 2'b00;
            d2_ra = {5'd0, 5'd3};
            #1 if (d2_stall !== 1'b0) stall_err++;
            for (int c = 0; c < D2; c++) begin
                @(negedge clk);
                d2_we = 1'b0; d2_ld = 1'b0; d2_re = 2'b01;
                #1 if (d2_stall !== 1'b1) stall_err++;
                stalls_m++;
            end
        end
        chk("deep_stall_pattern", 32'(stall_err), 32'h0);
        @(negedge clk);
        d2_iv = 1'b0; d2_re = 2'b00;
        #1 chk("stall_cnt_saturated", 32'(d2_cnt), 32'hFFFF);

        @(negedge clk);
        d2_iv = 1'b1; d2_we = 1'b1; d2_ld = 1'b1; d2_wa = 5'd3; d2_re = 2'b00;
        @(negedge clk);
        d2_we = 1'b0; d2_ld = 1'b0; d2_re = 2'b01;
        #1 chk("pre_reset_stall", 32'(d2_stall), 32'h1);
        #1 d2_rst = 1'b1;
        #1 chk("reset_drops_stall", 32'(d2_stall), 32'h0);
        chk("reset_clears_cnt", 32'(d2_cnt), 32'h0);
        chk("reset_clears_stages", 32'(d2_sv), 32'h0);
        @(negedge clk);
        d2_rst = 1'b0;
        #1 chk("post_reset_stall", 32'(d2_stall), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
